// File: rtl/ntsc_pkg.sv
// Shared NTSC constants for the line-timing generator and the synthesizer: colour codes, timing, horizontal states.
package ntsc_pkg;

    localparam logic [7:0] COL_SYNC  = 8'h80;
    localparam logic [7:0] COL_BLANK = 8'h81;
    localparam logic [7:0] COL_BURST = 8'h82;

    localparam logic [11:0] LINE_CLKS   = 12'd3178;
    localparam logic [11:0] HSYNC_CLKS  = 12'd235;
    localparam logic [11:0] BREEZE_CLKS = 12'd30;
    localparam logic [11:0] BURST_CLKS  = 12'd125;
    localparam logic [11:0] BACK_CLKS   = 12'd80;
    localparam logic [11:0] ACTIVE_CLKS = 12'd2630;
    localparam logic [11:0] FRONT_CLKS  = LINE_CLKS - HSYNC_CLKS - BREEZE_CLKS
                                        - BURST_CLKS - BACK_CLKS - ACTIVE_CLKS;
    localparam logic [11:0] BORDER_CLKS = 12'd35;
    localparam logic [3:0]  PIX_DIV     = 4'd10;

    localparam logic [8:0] FRAME_LINES_DEF  = 9'd262;
    localparam logic [8:0] VSYNC_LINES_DEF  = 9'd3;
    localparam logic [8:0] FIRST_ACTIVE_DEF = 9'd20;
    localparam logic [8:0] ACTIVE_LINES_DEF = 9'd240;

    typedef enum logic [2:0] {
        H_SYNC, H_BREEZE, H_BURST, H_BACK, H_ACTIVE, H_FRONT, H_VBLANK
    } hstate_t;

    // Final value of the state-local counter before leaving state s.
    function automatic logic [11:0] hstate_last(hstate_t s, logic vsync);
        case (s)
            H_SYNC:   hstate_last = vsync ? (LINE_CLKS - HSYNC_CLKS - 12'd1) : (HSYNC_CLKS - 12'd1);
            H_BREEZE: hstate_last = BREEZE_CLKS - 12'd1;
            H_BURST:  hstate_last = BURST_CLKS - 12'd1;
            H_BACK:   hstate_last = BACK_CLKS - 12'd1;
            H_ACTIVE: hstate_last = ACTIVE_CLKS - 12'd1;
            H_FRONT:  hstate_last = FRONT_CLKS - 12'd1;
            default:  hstate_last = HSYNC_CLKS - 12'd1;
        endcase
    endfunction

endpackage

// File: rtl/ntsc_line_timing_if.sv
// Pixel fetch handshake between line timing (master) and the frame source (slave).
interface ntsc_line_timing_if;
    logic       pix_req;
    logic [7:0] pix_x;
    logic [7:0] pix_y;
    logic [5:0] pix_data;

    modport master (output pix_req, pix_x, pix_y, input pix_data);
    modport slave  (input pix_req, pix_x, pix_y, output pix_data);
endinterface

// File: rtl/ntsc_pixel_fetch.sv
// Pixel divider and fetch pipeline: req 2 clks ahead of each pixel, data captured 1 clk after req.
// Latency: code valid combinationally in the capture clk; backpressure: none, source must answer in 1 clk.
module ntsc_pixel_fetch
    import ntsc_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [11:0] cnt,
    input  logic [7:0]  row,
    input  logic [5:0]  data,
    output logic        req,
    output logic [7:0]  x,
    output logic [7:0]  y,
    output logic        in_pix,
    output logic [5:0]  code
);
    localparam logic [11:0] REQ_START = BORDER_CLKS - 12'd2;
    localparam logic [11:0] PIX_END   = ACTIVE_CLKS - BORDER_CLKS;
    // Requests lead pixel starts by 2 clks, so captures fall on phase 2.
    localparam logic [3:0]  CAP_PHASE = 4'd2;

    logic [3:0] phase;
    logic [8:0] nreq;
    logic [5:0] pix_reg;
    logic       run;
    logic       req_d;
    logic       cap;

    always_comb begin
        run    = en && (cnt >= REQ_START);
        req_d  = run && (phase == 4'd0) && !nreq[8];
        in_pix = en && (cnt >= BORDER_CLKS) && (cnt < PIX_END);
        cap    = in_pix && (phase == CAP_PHASE);
        code   = cap ? data : pix_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase   <= '0;
            nreq    <= '0;
            pix_reg <= '0;
            req     <= 1'b0;
            x       <= '0;
            y       <= '0;
        end else begin
            req <= req_d;
            if (!run) begin
                phase <= '0;
                nreq  <= '0;
            end else begin
                phase <= (phase == PIX_DIV - 4'd1) ? 4'd0 : phase + 4'd1;
                if (req_d) nreq <= nreq + 9'd1;
            end
            if (req_d) begin
                x <= nreq[7:0];
                y <= row;
            end
            if (cap) pix_reg <= data;
        end
    end
endmodule

// File: rtl/ntsc_line_timing.sv
// NTSC 262-line timing generator emitting one colour code per clk, fetching 256x240 pixels on active lines.
// Latency: outputs registered one clk behind the internal state; backpressure: none, free-running.
module ntsc_line_timing
    import ntsc_pkg::*;
#(
    parameter logic [8:0] FRAME_LINES  = FRAME_LINES_DEF,
    parameter logic [8:0] VSYNC_LINES  = VSYNC_LINES_DEF,
    parameter logic [8:0] FIRST_ACTIVE = FIRST_ACTIVE_DEF,
    parameter logic [8:0] ACTIVE_LINES = ACTIVE_LINES_DEF
)(
    input  logic                      clk,
    input  logic                      reset,
    input  logic [5:0]                border,
    ntsc_line_timing_if.master        pix,
    output logic [7:0]                colourNum,
    output logic                      sync_n,
    output logic                      line_start,
    output logic                      frame_start
);
    hstate_t     state, state_nx;
    logic [11:0] cnt, cnt_nx;
    logic [8:0]  line, line_nx;
    logic        line_end;
    logic        vs, act_line, in_pix;
    logic [5:0]  pix_code;
    logic [7:0]  row, colour_nx;

    assign vs       = line < VSYNC_LINES;
    assign act_line = (line >= FIRST_ACTIVE) && (line < FIRST_ACTIVE + ACTIVE_LINES);
    assign row      = line[7:0] - FIRST_ACTIVE[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= H_SYNC;
            cnt   <= '0;
            line  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            line  <= line_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt + 12'd1;
        line_nx   = line;
        line_end  = 1'b0;
        colour_nx = COL_BLANK;
        if (cnt == hstate_last(state, vs)) begin
            cnt_nx = '0;
            case (state)
                H_SYNC:   state_nx = vs ? H_VBLANK : H_BREEZE;
                H_BREEZE: state_nx = H_BURST;
                H_BURST:  state_nx = H_BACK;
                H_BACK:   state_nx = H_ACTIVE;
                H_ACTIVE: state_nx = H_FRONT;
                default: begin
                    state_nx = H_SYNC;
                    line_end = 1'b1;
                end
            endcase
        end
        if (line_end) line_nx = (line == FRAME_LINES - 9'd1) ? 9'd0 : line + 9'd1;
        case (state)
            H_SYNC:   colour_nx = COL_SYNC;
            H_BURST:  colour_nx = COL_BURST;
            H_ACTIVE: colour_nx = {2'b00, in_pix ? pix_code : border};
            default:  colour_nx = COL_BLANK;
        endcase
    end

    // Registered look-ahead: outputs show the state the counters held on the previous clk.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            colourNum   <= COL_BLANK;
            sync_n      <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            colourNum   <= colour_nx;
            sync_n      <= (state != H_SYNC);
            line_start  <= (state == H_SYNC) && (cnt == 12'd0);
            frame_start <= (state == H_SYNC) && (cnt == 12'd0) && (line == 9'd0);
        end
    end

    ntsc_pixel_fetch u_fetch (
        .clk    (clk),
        .reset  (reset),
        .en     ((state == H_ACTIVE) && act_line),
        .cnt    (cnt),
        .row    (row),
        .data   (pix.pix_data),
        .req    (pix.pix_req),
        .x      (pix.pix_x),
        .y      (pix.pix_y),
        .in_pix (in_pix),
        .code   (pix_code)
    );
endmodule

// File: tb/tb_ntsc_line_timing.sv
// Directed bench for ntsc_line_timing: full horizontal timing, vertical frame shrunk to 10 lines
// (3 vsync, line 3 blank, lines 4..7 active, 8..9 blank) so whole frames fit in the run.
module tb_ntsc_line_timing;
    localparam int FL = 10;
    localparam int VS = 3;
    localparam int FA = 4;
    localparam int AL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] border;
    logic [7:0] colourNum;
    logic       sync_n, line_start, frame_start;

    ntsc_line_timing_if pix_bus();

    ntsc_line_timing #(
        .FRAME_LINES  (9'd10),
        .VSYNC_LINES  (9'd3),
        .FIRST_ACTIVE (9'd4),
        .ACTIVE_LINES (9'd4)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .border      (border),
        .pix         (pix_bus),
        .colourNum   (colourNum),
        .sync_n      (sync_n),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         t = 0;
    int         last_fs = -1;
    logic       req_seen = 1'b0;
    logic [7:0] req_x = 8'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // One clk: sample point is the falling edge; frame source answers a request in the next clk only.
    task automatic tick();
        @(negedge clk);
        t++;
        pix_bus.pix_data = req_seen ? req_x[5:0] : (req_x[5:0] ^ 6'h3F);
        req_seen = pix_bus.pix_req;
        req_x    = pix_bus.pix_x;
    endtask

    function automatic logic [7:0] exp_colour(input int L, input int h, input logic [5:0] b);
        int px;
        if (L < VS) return (h < 2943) ? 8'h80 : 8'h81;
        if (h < 235)   return 8'h80;
        if (h < 265)   return 8'h81;
        if (h < 390)   return 8'h82;
        if (h < 470)   return 8'h81;
        if (h >= 3100) return 8'h81;
        if (L >= FA && L < FA + AL && h >= 505 && h < 3065) begin
            px = (h - 505) / 10;
            return {2'b00, px[5:0]};
        end
        return {2'b00, b};
    endfunction

    task automatic scan_line(input int L, input int nclk);
        int         bad_col = 0, bad_sync = 0, bad_ls = 0, bad_fs = 0, bad_req = 0, bad_xy = 0, nreq = 0;
        int         k;
        logic [5:0] bdr = border;
        logic [7:0] ec;
        logic       er;
        for (int h = 0; h < nclk; h++) begin
            tick();
            ec = exp_colour(L, h, bdr);
            k  = h - 503;
            er = (L >= FA) && (L < FA + AL) && (k >= 0) && (k % 10 == 0) && (k / 10 < 256);
            if (colourNum !== ec)                      bad_col++;
            if (sync_n !== (ec != 8'h80))              bad_sync++;
            if (line_start !== (h == 0))               bad_ls++;
            if (frame_start !== (h == 0 && L == 0))    bad_fs++;
            if (pix_bus.pix_req !== er)                bad_req++;
            if (er) begin
                nreq++;
                if (pix_bus.pix_x !== 8'(k / 10) || pix_bus.pix_y !== 8'(L - FA)) bad_xy++;
            end
            if (frame_start === 1'b1) begin
                if (last_fs >= 0) check("frame period", t - last_fs, FL * 3178);
                last_fs = t;
            end
            if (L == 8 && h == 1500) border = 6'h15;
            if (L == 8 && h == 2500) border = 6'h0F;
            if (L == 6 && h == 3080) border = 6'h21;
            if (L == 6 && h == 3090) border = 6'h0F;
            bdr = border;
        end
        check($sformatf("L%0d colourNum", L), bad_col, 0);
        check($sformatf("L%0d sync_n", L), bad_sync, 0);
        check($sformatf("L%0d line_start", L), bad_ls, 0);
        check($sformatf("L%0d frame_start", L), bad_fs, 0);
        check($sformatf("L%0d pix_req timing", L), bad_req, 0);
        check($sformatf("L%0d pix_x/pix_y", L), bad_xy, 0);
        if (nclk == 3178) check($sformatf("L%0d request count", L), nreq, (L >= FA && L < FA + AL) ? 256 : 0);
    endtask

    initial begin
        rst              = 1'b0;
        border           = 6'h0F;
        pix_bus.pix_data = 6'h00;
        repeat (3) @(negedge clk);
        check("reset colourNum", colourNum, 8'h81);
        check("reset sync_n", sync_n, 1'b1);
        check("reset pix_req", pix_bus.pix_req, 1'b0);
        check("reset pix_x", pix_bus.pix_x, 8'd0);
        check("reset pix_y", pix_bus.pix_y, 8'd0);
        check("reset line_start", line_start, 1'b0);
        check("reset frame_start", frame_start, 1'b0);
        rst = 1'b1;

        for (int n = 0; n < FL + 5; n++) scan_line(n % FL, 3178);

        // Line 5 stops at hcnt 1003, a request clk (pixel 50)
        scan_line(5, 1004);
        check("pre-reset pix_req", pix_bus.pix_req, 1'b1);
        check("pre-reset pix_x", pix_bus.pix_x, 8'd50);
        rst = 1'b0;
        #1;
        check("async reset colourNum", colourNum, 8'h81);
        check("async reset pix_req", pix_bus.pix_req, 1'b0);
        check("async reset pix_x", pix_bus.pix_x, 8'd0);
        check("async reset pix_y", pix_bus.pix_y, 8'd0);
        check("async reset sync_n", sync_n, 1'b1);
        repeat (3) tick();
        check("held reset colourNum", colourNum, 8'h81);
        check("held reset pix_req", pix_bus.pix_req, 1'b0);
        rst     = 1'b1;
        last_fs = -1;
        scan_line(0, 3178);
        scan_line(1, 3178);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
